// File: rtl/fetch_realigner_pkg.sv
// Shared types and helpers for the fetch block re-aligner.
// Slot counts depend on fetch width and whether RVC is enabled.
package fetch_realigner_pkg;

  localparam int unsigned NP       = 4;
  localparam int unsigned MAX_VLEN = 64;

  typedef struct packed {
    logic [NP-1:0]               valid;
    logic [NP-1:0][MAX_VLEN-1:0] addr;
    logic [NP-1:0][31:0]         instr;
  } fetch_bundle_t;

  function automatic int unsigned instr_per_fetch(
    input int unsigned fw,
    input bit          rvc
  );
    return rvc ? fw / 16 : fw / 32;
  endfunction

  function automatic logic is_rvc(input logic [15:0] p);
    return p[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_parcel_scanner.sv
// Combinational parcel scan of one fetch block, with carry-in/out
// of a split 32-bit instruction, followed by slot compaction.
module fetch_parcel_scanner
  import fetch_realigner_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 64,
  parameter int unsigned VLEN        = 64,
  parameter bit          RVC         = 1'b1,
  localparam int unsigned IPF = instr_per_fetch(FETCH_WIDTH, RVC)
) (
  input  logic [VLEN-1:0]           address_i,
  input  logic [FETCH_WIDTH-1:0]    data_i,
  input  logic                      unaligned_i,
  input  logic [15:0]               carry_i,
  input  logic [VLEN-1:0]           carry_addr_i,
  output logic [IPF-1:0]            valid_o,
  output logic [IPF-1:0][VLEN-1:0]  addr_o,
  output logic [IPF-1:0][31:0]      instr_o,
  output logic                      unaligned_o,
  output logic [15:0]               carry_o,
  output logic [VLEN-1:0]           carry_addr_o
);

  localparam int unsigned NPAR = FETCH_WIDTH / 16;
  localparam int unsigned BW   = $clog2(FETCH_WIDTH / 8);

  logic [NPAR-1:0][15:0]     p;
  logic [VLEN-1:0]           base;
  logic [BW-2:0]             s;
  logic [NPAR-1:0]           raw_v;
  logic [NPAR-1:0][31:0]     raw_i;
  logic [NPAR-1:0][VLEN-1:0] raw_a;

  assign p    = data_i;
  assign base = address_i & ~VLEN'(FETCH_WIDTH / 8 - 1);
  assign s    = address_i[BW-1:1];

  // Results are first placed at their starting parcel, then compacted.
  always_comb begin
    logic skip;
    skip         = 1'b0;
    raw_v        = '0;
    raw_i        = '0;
    raw_a        = '0;
    unaligned_o  = 1'b0;
    carry_o      = '0;
    carry_addr_o = '0;
    if (RVC) begin
      for (int j = 0; j < NPAR; j++) begin
        if (skip) begin
          skip = 1'b0;
        end else if (j == 0 && unaligned_i && s == '0) begin
          raw_v[0] = 1'b1;
          raw_i[0] = {p[0], carry_i};
          raw_a[0] = carry_addr_i;
        end else if (j >= int'(s)) begin
          raw_a[j] = base + VLEN'(2 * j);
          if (is_rvc(p[j])) begin
            raw_v[j] = 1'b1;
            raw_i[j] = {16'h0, p[j]};
          end else if (j < NPAR - 1) begin
            raw_v[j] = 1'b1;
            raw_i[j] = {p[(j + 1) % NPAR], p[j]};
            skip     = 1'b1;
          end else begin
            unaligned_o  = 1'b1;
            carry_o      = p[j];
            carry_addr_o = base + VLEN'(2 * j);
          end
        end
      end
    end else begin
      for (int j = 0; j < NPAR; j += 2) begin
        if (j / 2 >= int'(s) / 2) begin
          raw_v[j] = 1'b1;
          raw_i[j] = {p[j + 1], p[j]};
          raw_a[j] = base + VLEN'(2 * j);
        end
      end
    end
  end

  always_comb begin
    int k;
    k       = 0;
    valid_o = '0;
    addr_o  = '0;
    instr_o = '0;
    for (int j = 0; j < NPAR; j++) begin
      if (raw_v[j]) begin
        for (int m = 0; m < IPF; m++) begin
          if (m == k) begin
            valid_o[m] = 1'b1;
            addr_o[m]  = raw_a[j];
            instr_o[m] = raw_i[j];
          end
        end
        k++;
      end
    end
  end

endmodule

// File: rtl/fetch_realigner.sv
// Fetch block re-aligner: carry registers, optional output bundle
// register and valid/ready handshake around the parcel scanner.
module fetch_realigner
  import fetch_realigner_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 64,
  parameter int unsigned VLEN        = 64,
  parameter bit          RVC         = 1'b1,
  parameter bit          OUT_REG     = 1'b1,
  localparam int unsigned IPF = instr_per_fetch(FETCH_WIDTH, RVC)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [VLEN-1:0]          address_i,
  input  logic [FETCH_WIDTH-1:0]   data_i,
  output logic [IPF-1:0]           valid_o,
  output logic [IPF-1:0][VLEN-1:0] addr_o,
  output logic [IPF-1:0][31:0]     instr_o,
  input  logic                     ready_i,
  output logic                     serving_unaligned_o
);

  if (FETCH_WIDTH != 32 && FETCH_WIDTH != 64 && FETCH_WIDTH != 128) begin : g_bad_width
    $error("fetch_realigner: FETCH_WIDTH must be 32, 64 or 128");
  end

  logic [IPF-1:0]           scan_v;
  logic [IPF-1:0][VLEN-1:0] scan_a;
  logic [IPF-1:0][31:0]     scan_i;
  logic                     scan_unal;
  logic [15:0]              scan_carry;
  logic [VLEN-1:0]          scan_caddr;
  logic                     unaligned_q;
  logic [15:0]              carry_q;
  logic [VLEN-1:0]          carry_addr_q;
  logic                     accept;

  fetch_parcel_scanner #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .VLEN        (VLEN),
    .RVC         (RVC)
  ) u_scan (
    .address_i    (address_i),
    .data_i       (data_i),
    .unaligned_i  (unaligned_q),
    .carry_i      (carry_q),
    .carry_addr_i (carry_addr_q),
    .valid_o      (scan_v),
    .addr_o       (scan_a),
    .instr_o      (scan_i),
    .unaligned_o  (scan_unal),
    .carry_o      (scan_carry),
    .carry_addr_o (scan_caddr)
  );

  assign accept              = valid_i && ready_o && !flush_i;
  assign serving_unaligned_o = unaligned_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unaligned_q  <= 1'b0;
      carry_q      <= '0;
      carry_addr_q <= '0;
    end else if (flush_i) begin
      unaligned_q <= 1'b0;
    end else if (accept) begin
      unaligned_q  <= RVC && scan_unal;
      carry_q      <= scan_carry;
      carry_addr_q <= scan_caddr;
    end
  end

  if (OUT_REG) begin : g_reg
    logic [IPF-1:0]           bv_q;
    logic [IPF-1:0][VLEN-1:0] addr_q;
    logic [IPF-1:0][31:0]     instr_q;

    assign ready_o = ~|bv_q | ready_i;
    assign valid_o = bv_q;
    assign addr_o  = addr_q;
    assign instr_o = instr_q;

    // Empty scan results never occupy the register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        bv_q    <= '0;
        addr_q  <= '0;
        instr_q <= '0;
      end else if (flush_i) begin
        bv_q    <= '0;
        instr_q <= '0;
      end else if (accept && |scan_v) begin
        bv_q    <= scan_v;
        addr_q  <= scan_a;
        instr_q <= scan_i;
      end else if (ready_i) begin
        bv_q    <= '0;
        instr_q <= '0;
      end
    end
  end else begin : g_comb
    logic show;
    assign show    = valid_i & ~flush_i;
    assign ready_o = ready_i;
    assign valid_o = show ? scan_v : '0;
    assign addr_o  = scan_a;
    assign instr_o = show ? scan_i : '0;
  end

endmodule
